// File: rtl/fp_const_pkg.sv
// Shared constants, FSM encoding and the common round/pack helper for the
// single-precision units used by the HSV-to-RGB converter.
package fp_const_pkg;

  localparam logic [31:0] FP_ZERO = 32'h0000_0000;
  localparam logic [31:0] FP_ONE  = 32'h3F80_0000;
  localparam logic [31:0] FP_60   = 32'h4270_0000;
  localparam logic [31:0] FP_255  = 32'h437F_0000;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_C_MUL  = 4'd1,
    S_H_DIV  = 4'd2,
    S_SECT   = 4'd3,
    S_T_CALC = 4'd4,
    S_X_MUL  = 4'd5,
    S_M_SUB  = 4'd6,
    S_R_ADD  = 4'd7,
    S_G_ADD  = 4'd8,
    S_B_ADD  = 4'd9,
    S_R_SCL  = 4'd10,
    S_G_SCL  = 4'd11,
    S_B_SCL  = 4'd12,
    S_DONE   = 4'd13
  } state_t;

  // Round-to-nearest-even on a normalised 24-bit mantissa (hidden bit at [23]),
  // then pack. Underflow flushes to zero, overflow saturates to infinity.
  function automatic logic [31:0] fp_pack(input logic sgn, input logic signed [10:0] exp_i,
                                          input logic [23:0] mant, input logic grd,
                                          input logic stk);
    logic [24:0]        mr;
    logic signed [10:0] e;
    mr = {1'b0, mant} + {24'd0, grd & (stk | mant[0])};
    e  = exp_i;
    if (mr[24]) begin
      mr = mr >> 1;
      e  = e + 11'sd1;
    end
    if (e <= 11'sd0)        fp_pack = 32'd0;
    else if (e >= 11'sd255) fp_pack = {sgn, 8'hFF, 23'd0};
    else                    fp_pack = {sgn, e[7:0], mr[22:0]};
  endfunction

endpackage

// File: rtl/fp_add.sv
// Combinational single-precision adder (normals and zero; denormals read as zero).
module fp_add
  import fp_const_pkg::*;
(
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic [31:0] o_y
);
  logic               w_swap;
  logic [31:0]        w_big, w_sml;
  logic [7:0]         w_d;
  logic [4:0]         w_sh, w_lz;
  logic [26:0]        w_mb, w_ms, w_nrm;
  logic [53:0]        w_shf;
  logic [27:0]        w_sum;
  logic signed [10:0] w_exp;

  // Align the smaller operand (with sticky), add or subtract, normalise, round
  always_comb begin
    w_swap = i_b[30:0] > i_a[30:0];
    w_big  = w_swap ? i_b : i_a;
    w_sml  = w_swap ? i_a : i_b;
    w_d    = w_big[30:23] - w_sml[30:23];
    w_sh   = (w_d > 8'd27) ? 5'd27 : w_d[4:0];
    w_mb   = {1'b1, w_big[22:0], 3'b000};
    w_shf  = {1'b1, w_sml[22:0], 3'b000, 27'd0} >> w_sh;
    w_ms   = w_shf[53:27] | {26'd0, |w_shf[26:0]};
    w_exp  = $signed({3'b000, w_big[30:23]});
    w_sum  = '0;
    w_nrm  = '0;
    w_lz   = '0;
    if (w_big[31] == w_sml[31]) begin
      w_sum = {1'b0, w_mb} + {1'b0, w_ms};
      if (w_sum[27]) begin
        w_nrm = {w_sum[27:2], w_sum[1] | w_sum[0]};
        w_exp = w_exp + 11'sd1;
      end else begin
        w_nrm = w_sum[26:0];
      end
    end else begin
      w_sum = {1'b0, w_mb - w_ms};
      for (int i = 0; i < 27; i++)
        if (w_sum[i]) w_lz = 5'(26 - i);
      w_nrm = w_sum[26:0] << w_lz;
      w_exp = w_exp - $signed({6'd0, w_lz});
    end
    if (i_a[30:23] == 8'd0)      o_y = i_b;
    else if (i_b[30:23] == 8'd0) o_y = i_a;
    else if (w_nrm == 27'd0)     o_y = FP_ZERO;
    else o_y = fp_pack(w_big[31], w_exp, w_nrm[26:3], w_nrm[2], |w_nrm[1:0]);
  end
endmodule

// File: rtl/fp_div.sv
// Combinational single-precision divider; the divisor is assumed non-zero.
module fp_div
  import fp_const_pkg::*;
(
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic [31:0] o_y
);
  logic [48:0]        w_num, w_den;
  logic [25:0]        w_q;
  logic               w_rem_nz;
  logic signed [10:0] w_exp;

  assign w_num    = {1'b1, i_a[22:0], 25'd0};
  assign w_den    = {25'd0, 1'b1, i_b[22:0]};
  assign w_q      = 26'(w_num / w_den);
  assign w_rem_nz = (w_num % w_den) != 49'd0;

  // Mantissa ratio lies in (0.5,2): two normalisation cases
  always_comb begin
    w_exp = $signed({3'b000, i_a[30:23]}) - $signed({3'b000, i_b[30:23]}) + 11'sd126;
    if (i_a[30:23] == 8'd0) o_y = FP_ZERO;
    else if (w_q[25])
      o_y = fp_pack(i_a[31] ^ i_b[31], w_exp + 11'sd1, w_q[25:2], w_q[1], w_q[0] | w_rem_nz);
    else
      o_y = fp_pack(i_a[31] ^ i_b[31], w_exp, w_q[24:1], w_q[0], w_rem_nz);
  end
endmodule

// File: rtl/fp_mul.sv
// Combinational single-precision multiplier (zero operand gives +0).
module fp_mul
  import fp_const_pkg::*;
(
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic [31:0] o_y
);
  logic [47:0]        w_prod;
  logic [23:0]        w_mant;
  logic               w_grd, w_stk;
  logic signed [10:0] w_exp;

  assign w_prod = {24'd0, 1'b1, i_a[22:0]} * {24'd0, 1'b1, i_b[22:0]};

  // Product lies in [1,4): pick the normalisation, then round and pack
  always_comb begin
    w_exp = $signed({3'b000, i_a[30:23]}) + $signed({3'b000, i_b[30:23]}) - 11'sd127;
    if (w_prod[47]) begin
      w_mant = w_prod[47:24];
      w_grd  = w_prod[23];
      w_stk  = |w_prod[22:0];
      w_exp  = w_exp + 11'sd1;
    end else begin
      w_mant = w_prod[46:23];
      w_grd  = w_prod[22];
      w_stk  = |w_prod[21:0];
    end
    if (i_a[30:23] == 8'd0 || i_b[30:23] == 8'd0) o_y = FP_ZERO;
    else o_y = fp_pack(i_a[31] ^ i_b[31], w_exp, w_mant, w_grd, w_stk);
  end
endmodule

// File: rtl/fp_sector.sv
// Splits H' in [0,6] into integer sector k and float fraction f using pure
// shifts; k = 6 (h = 360) wraps to sector 0 with the same fraction bits.
module fp_sector
  import fp_const_pkg::*;
(
  input  logic [31:0] i_hp,
  output logic [2:0]  o_k,
  output logic [31:0] o_f
);
  logic [23:0] w_man;
  logic [1:0]  w_sh;
  logic [2:0]  w_int;
  logic [22:0] w_fb, w_fm;
  logic [4:0]  w_p;

  // Floor via mantissa shift, then renormalise the leftover fraction bits
  always_comb begin
    w_man = {1'b1, i_hp[22:0]};
    w_sh  = '0;
    w_int = '0;
    w_fb  = '0;
    w_fm  = '0;
    w_p   = '0;
    o_k   = 3'd0;
    o_f   = i_hp;
    if (i_hp[30:23] >= 8'd127 && i_hp[30:23] <= 8'd129) begin
      w_sh  = 2'(i_hp[30:23] - 8'd127);
      w_int = 3'(w_man >> (5'd23 - {3'd0, w_sh}));
      w_fb  = 23'(w_man << w_sh);
      for (int i = 0; i < 23; i++)
        if (w_fb[i]) w_p = 5'(i);
      w_fm  = w_fb << (5'd23 - w_p);
      o_k   = (w_int >= 3'd6) ? 3'd0 : w_int;
      o_f   = (w_fb == 23'd0) ? FP_ZERO : {1'b0, 8'(8'd104 + {3'd0, w_p}), w_fm};
    end
  end
endmodule

// File: rtl/fp_sub.sv
// Combinational single-precision subtractor: a - b as a + (-b).
module fp_sub (
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic [31:0] o_y
);
  fp_add u_add (.i_a(i_a), .i_b({~i_b[31], i_b[30:0]}), .o_y(o_y));
endmodule

// File: rtl/floating_point_hsvtorgb.sv
// HSV to RGB converter in IEEE single precision: a fixed 13-state sequence
// time-shares one adder, subtractor, multiplier and divider.
module floating_point_hsvtorgb
  import fp_const_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] h,
  input  logic [31:0] s,
  input  logic [31:0] v,
  input  logic        data_val_in,
  output logic        ready,
  output logic [31:0] r,
  output logic [31:0] g,
  output logic [31:0] b,
  output logic        data_val_out
);
  state_t      r_state, w_next;
  logic [31:0] r_h, r_s, r_v, r_c, r_hp, r_f, r_t, r_x, r_m, r_sr, r_sg, r_sb;
  logic [31:0] r_r, r_g, r_b;
  logic [2:0]  r_k, w_k;
  logic [31:0] w_f, w_r1, w_g1, w_b1;
  logic [31:0] w_add_a, w_add_b, w_add_y, w_sub_a, w_sub_b, w_sub_y;
  logic [31:0] w_mul_a, w_mul_b, w_mul_y, w_div_a, w_div_b, w_div_y;

  fp_add    u_add    (.i_a(w_add_a), .i_b(w_add_b), .o_y(w_add_y));
  fp_sub    u_sub    (.i_a(w_sub_a), .i_b(w_sub_b), .o_y(w_sub_y));
  fp_mul    u_mul    (.i_a(w_mul_a), .i_b(w_mul_b), .o_y(w_mul_y));
  fp_div    u_div    (.i_a(w_div_a), .i_b(w_div_b), .o_y(w_div_y));
  fp_sector u_sector (.i_hp(r_hp), .o_k(w_k), .o_f(w_f));

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next state: wait in IDLE for a sample, otherwise step unconditionally
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (data_val_in) w_next = S_C_MUL;
      S_DONE:  w_next = S_IDLE;
      default: w_next = state_t'(r_state + 4'd1);
    endcase
  end

  // FSM outputs
  always_comb begin
    ready        = (r_state == S_IDLE);
    data_val_out = (r_state == S_DONE);
  end

  // Pre-offset channel values for the current sector
  always_comb begin
    case (r_k)
      3'd1:    begin w_r1 = r_x;     w_g1 = r_c;     w_b1 = FP_ZERO; end
      3'd2:    begin w_r1 = FP_ZERO; w_g1 = r_c;     w_b1 = r_x;     end
      3'd3:    begin w_r1 = FP_ZERO; w_g1 = r_x;     w_b1 = r_c;     end
      3'd4:    begin w_r1 = r_x;     w_g1 = FP_ZERO; w_b1 = r_c;     end
      3'd5:    begin w_r1 = r_c;     w_g1 = FP_ZERO; w_b1 = r_x;     end
      default: begin w_r1 = r_c;     w_g1 = r_x;     w_b1 = FP_ZERO; end
    endcase
  end

  // Operand muxes for the shared arithmetic units
  always_comb begin
    w_mul_a = r_v;   w_mul_b = r_s;
    w_sub_a = r_v;   w_sub_b = r_c;
    w_add_a = r_m;   w_add_b = w_r1;
    w_div_a = r_h;   w_div_b = FP_60;
    case (r_state)
      S_X_MUL:  begin w_mul_a = r_c;  w_mul_b = r_t;    end
      S_R_SCL:  begin w_mul_a = r_sr; w_mul_b = FP_255; end
      S_G_SCL:  begin w_mul_a = r_sg; w_mul_b = FP_255; end
      S_B_SCL:  begin w_mul_a = r_sb; w_mul_b = FP_255; end
      S_T_CALC: begin w_sub_a = FP_ONE; w_sub_b = r_f;  end
      S_G_ADD:  w_add_b = w_g1;
      S_B_ADD:  w_add_b = w_b1;
      default:  ;
    endcase
  end

  // Intermediate results, each captured in the state that produces it
  always_ff @(posedge clk) begin
    case (r_state)
      S_IDLE: if (data_val_in) begin
        r_h <= h & 32'h7FFF_FFFF;
        r_s <= s & 32'h7FFF_FFFF;
        r_v <= v & 32'h7FFF_FFFF;
      end
      S_C_MUL:  r_c  <= w_mul_y;
      S_H_DIV:  r_hp <= w_div_y;
      S_SECT:   begin r_k <= w_k; r_f <= w_f; end
      S_T_CALC: r_t  <= r_k[0] ? w_sub_y : r_f;
      S_X_MUL:  r_x  <= w_mul_y;
      S_M_SUB:  r_m  <= w_sub_y;
      S_R_ADD:  r_sr <= w_add_y;
      S_G_ADD:  r_sg <= w_add_y;
      S_B_ADD:  r_sb <= w_add_y;
      default:  ;
    endcase
  end

  // Output registers hold the last completed result
  always_ff @(posedge clk) begin
    if (rst) begin
      r_r <= FP_ZERO;
      r_g <= FP_ZERO;
      r_b <= FP_ZERO;
    end else begin
      case (r_state)
        S_R_SCL: r_r <= w_mul_y;
        S_G_SCL: r_g <= w_mul_y;
        S_B_SCL: r_b <= w_mul_y;
        default: ;
      endcase
    end
  end

  assign r = r_r;
  assign g = r_g;
  assign b = r_b;
endmodule

// File: tb/tb_floating_point_hsvtorgb.sv
// Scoreboard bench: stimulus pushes expected RGB into queues, a negedge
// monitor pops and compares on every data_val_out pulse.
module tb_floating_point_hsvtorgb;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] h, s, v;
  logic        data_val_in;
  logic        ready;
  logic [31:0] r, g, b;
  logic        data_val_out;

  floating_point_hsvtorgb dut (
    .clk(clk), .rst(rst), .h(h), .s(s), .v(v), .data_val_in(data_val_in),
    .ready(ready), .r(r), .g(g), .b(b), .data_val_out(data_val_out)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          q_acc[$];
  bit          q_ex[$];
  logic [31:0] q_er[$], q_eg[$], q_eb[$];
  real         q_fr[$], q_fg[$], q_fb[$];

  task automatic chk_bits(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  task automatic chk_real(input string nm, input real act, input real exp);
    real d;
    checks++;
    d = act - exp;
    if (d < 0.0) d = -d;
    if (d > 0.05) begin
      errors++;
      $display("FAIL %s got=%f want=%f", nm, act, exp);
    end
  endtask

  function automatic real f2r(input logic [31:0] x);
    real m;
    int  e;
    if (x[30:23] == 8'd0) return 0.0;
    m = 1.0 + real'(x[22:0]) / 8388608.0;
    e = int'(x[30:23]) - 127;
    while (e > 0) begin m = m * 2.0; e--; end
    while (e < 0) begin m = m / 2.0; e++; end
    return x[31] ? -m : m;
  endfunction

  function automatic logic [31:0] r2f(input real x);
    real y;
    int  e;
    if (x <= 0.0) return 32'h0;
    y = x;
    e = 127;
    while (y >= 2.0) begin y = y / 2.0; e++; end
    while (y < 1.0)  begin y = y * 2.0; e--; end
    return {1'b0, 8'(e), 23'($rtoi((y - 1.0) * 8388608.0))};
  endfunction

  // Textbook HSV->RGB in double precision, scaled to 0..255
  task automatic hsv_ref(input real hh, input real ss, input real vv,
                         output real rr, output real gg, output real bb);
    real c, hp, md, x, m, r1, g1, b1;
    int  sec;
    c  = vv * ss;
    hp = hh / 60.0;
    md = hp - 2.0 * $floor(hp / 2.0);
    x  = c * (1.0 - ((md >= 1.0) ? md - 1.0 : 1.0 - md));
    m  = vv - c;
    sec = $rtoi($floor(hp)) % 6;
    case (sec)
      0: begin r1 = c;   g1 = x;   b1 = 0.0; end
      1: begin r1 = x;   g1 = c;   b1 = 0.0; end
      2: begin r1 = 0.0; g1 = c;   b1 = x;   end
      3: begin r1 = 0.0; g1 = x;   b1 = c;   end
      4: begin r1 = x;   g1 = 0.0; b1 = c;   end
      default: begin r1 = c; g1 = 0.0; b1 = x; end
    endcase
    rr = (r1 + m) * 255.0;
    gg = (g1 + m) * 255.0;
    bb = (b1 + m) * 255.0;
  endtask

  // Called at a negedge; returns at the negedge right after the accepting edge
  task automatic issue(input logic [31:0] hh, input logic [31:0] ss, input logic [31:0] vv,
                       input bit push, input bit ex, input logic [31:0] er,
                       input logic [31:0] eg, input logic [31:0] eb, output int acc);
    int  n;
    real rr, gg, bb;
    n = 0;
    while (!ready && n < 40) begin @(negedge clk); n++; end
    if (!ready) begin
      checks++; errors++;
      $display("FAIL ready_timeout got=0 want=1");
    end
    h = hh; s = ss; v = vv; data_val_in = 1'b1;
    @(negedge clk);
    data_val_in = 1'b0;
    acc = cyc;
    if (push) begin
      hsv_ref(f2r({1'b0, hh[30:0]}), f2r({1'b0, ss[30:0]}), f2r({1'b0, vv[30:0]}), rr, gg, bb);
      q_acc.push_back(acc); q_ex.push_back(ex);
      q_er.push_back(er);   q_eg.push_back(eg);   q_eb.push_back(eb);
      q_fr.push_back(rr);   q_fg.push_back(gg);   q_fb.push_back(bb);
    end
  endtask

  // Monitor
  bit          prev_dvo = 1'b0;
  int          m_acc;
  bit          m_ex;
  logic [31:0] m_er, m_eg, m_eb;
  real         m_fr, m_fg, m_fb;
  always @(negedge clk) begin
    if (prev_dvo) chk_bits("pulse_width", {31'd0, data_val_out}, 32'd0);
    prev_dvo = data_val_out;
    if (data_val_out) begin
      if (q_acc.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_pulse got=1 want=0");
      end else begin
        m_acc = q_acc.pop_front(); m_ex = q_ex.pop_front();
        m_er = q_er.pop_front(); m_eg = q_eg.pop_front(); m_eb = q_eb.pop_front();
        m_fr = q_fr.pop_front(); m_fg = q_fg.pop_front(); m_fb = q_fb.pop_front();
        chk_bits("latency", 32'(cyc + 1 - m_acc), 32'd13);
        if (m_ex) begin
          chk_bits("r_exact", r, m_er);
          chk_bits("g_exact", g, m_eg);
          chk_bits("b_exact", b, m_eb);
        end else begin
          chk_real("r_val", f2r(r), m_fr);
          chk_real("g_val", f2r(g), m_fg);
          chk_real("b_val", f2r(b), m_fb);
        end
      end
    end
  end

  localparam logic [31:0] F0 = 32'h0, F1 = 32'h3F80_0000, F255 = 32'h437F_0000;

  initial begin
    int          acc, n;
    logic [31:0] rh, rs, rv;
    rst = 1'b1; data_val_in = 1'b0; h = '0; s = '0; v = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk_bits("rst_ready", {31'd0, ready}, 32'd1);
    chk_bits("rst_dvo", {31'd0, data_val_out}, 32'd0);
    chk_bits("rst_r", r, F0);
    chk_bits("rst_g", g, F0);
    chk_bits("rst_b", b, F0);

    // Directed exact cases
    issue(32'h0000_0000, F1, F1, 1, 1, F255, F0, F0, acc);
    issue(32'h42F0_0000, F1, F1, 1, 1, F0, F255, F0, acc);
    issue(32'h4370_0000, F1, F1, 1, 1, F0, F0, F255, acc);
    issue(32'h4270_0000, F1, F1, 1, 1, F255, F255, F0, acc);
    issue(32'h43B4_0000, F1, F1, 1, 1, F255, F0, F0, acc);
    issue(32'h4348_0000, F0, 32'h3F00_0000, 1, 1, 32'h42FF_0000, 32'h42FF_0000, 32'h42FF_0000, acc);
    issue(32'hC2F0_0000, 32'hBF80_0000, 32'hBF80_0000, 1, 1, F0, F255, F0, acc);

    // Busy-time and DONE-cycle requests are dropped
    issue(32'h42F0_0000, F1, F1, 1, 1, F0, F255, F0, acc);
    repeat (4) @(negedge clk);
    h = 32'h4370_0000; data_val_in = 1'b1;
    chk_bits("busy_ready", {31'd0, ready}, 32'd0);
    @(negedge clk);
    data_val_in = 1'b0;
    while (cyc < acc + 12) @(negedge clk);
    data_val_in = 1'b1;
    chk_bits("done_ready", {31'd0, ready}, 32'd0);
    chk_bits("done_dvo", {31'd0, data_val_out}, 32'd1);
    @(negedge clk);
    data_val_in = 1'b0;
    chk_bits("ready_after_done", {31'd0, ready}, 32'd1);

    // Reset during X_MUL aborts silently
    issue(32'h4370_0000, F1, F1, 0, 0, F0, F0, F0, acc);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_bits("abort_r", r, F0);
    chk_bits("abort_g", g, F0);
    chk_bits("abort_b", b, F0);
    chk_bits("abort_ready", {31'd0, ready}, 32'd1);
    chk_bits("abort_dvo", {31'd0, data_val_out}, 32'd0);
    repeat (16) @(negedge clk);
    issue(32'h42F0_0000, F1, F1, 1, 1, F0, F255, F0, acc);

    // Random samples against the reference model
    for (int i = 0; i < 40; i++) begin
      rh = r2f(real'($urandom_range(0, 36000)) / 100.0);
      rs = r2f(real'($urandom_range(0, 1000)) / 1000.0);
      rv = r2f(real'($urandom_range(0, 1000)) / 1000.0);
      if ($urandom_range(0, 3) == 0) rh[31] = 1'b1;
      if ($urandom_range(0, 3) == 0) rs[31] = 1'b1;
      issue(rh, rs, rv, 1, 0, F0, F0, F0, acc);
    end

    n = 0;
    while (q_acc.size() != 0 && n < 60) begin @(negedge clk); n++; end
    if (q_acc.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain got=%0d want=0", q_acc.size());
    end
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
